// File: rtl/cue_shot_controller.sv
// cue_shot_controller
// Aims and charges a cue shot while the cue ball is at rest, then issues a
// single-cycle velocity write carrying the launch vector. All outputs are
// registered; the only feedback from the ball is ballStopped.
module cue_shot_controller #(
  parameter int unsigned MAX_POWER      = 200,
  parameter int unsigned CHARGE_STEP    = 4,
  parameter int unsigned LAUNCH_TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               ballStopped,
  input  logic               aimLeft,
  input  logic               aimRight,
  input  logic               shootBtn,
  output logic               velocityWriteEnable,
  output logic signed [10:0] outVelocityX,
  output logic signed [10:0] outVelocityY,
  output logic [3:0]         aimIndex,
  output logic [7:0]         power,
  output logic [7:0]         shotCount,
  output logic [2:0]         state
);

  localparam int unsigned TW = (LAUNCH_TIMEOUT > 1) ? $clog2(LAUNCH_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(LAUNCH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    WAIT_STOP = 3'd0,
    AIM       = 3'd1,
    CHARGE    = 3'd2,
    FIRE      = 3'd3,
    LAUNCH    = 3'd4
  } state_t;

  state_t cur_state, nxt_state;

  logic [TW-1:0]      timer_q, timer_d;
  logic [3:0]         aim_d;
  logic [7:0]         power_d, count_d;
  logic               we_d;
  logic signed [10:0] vx_d, vy_d;

  logic [8:0]         charge_sum;
  logic signed [8:0]  power_s;
  logic signed [7:0]  cos_v, sin_v;
  logic signed [16:0] prod_x, prod_y, adj_x, adj_y;

  // Q6 cosine for the 16 aim directions (22.5 degree steps)
  function automatic logic signed [7:0] cos_q6(input logic [3:0] k);
    case (k)
      4'd0:    cos_q6 =  8'sd64;
      4'd1:    cos_q6 =  8'sd59;
      4'd2:    cos_q6 =  8'sd45;
      4'd3:    cos_q6 =  8'sd24;
      4'd4:    cos_q6 =  8'sd0;
      4'd5:    cos_q6 = -8'sd24;
      4'd6:    cos_q6 = -8'sd45;
      4'd7:    cos_q6 = -8'sd59;
      4'd8:    cos_q6 = -8'sd64;
      4'd9:    cos_q6 = -8'sd59;
      4'd10:   cos_q6 = -8'sd45;
      4'd11:   cos_q6 = -8'sd24;
      4'd12:   cos_q6 =  8'sd0;
      4'd13:   cos_q6 =  8'sd24;
      4'd14:   cos_q6 =  8'sd45;
      default: cos_q6 =  8'sd59;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) cur_state <= WAIT_STOP;
    else        cur_state <= nxt_state;
  end

  // Next-state logic; losing ballStopped in AIM/CHARGE/LAUNCH always wins
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      WAIT_STOP: if (startOfFrame && ballStopped) nxt_state = AIM;
      AIM: begin
        if (!ballStopped)                   nxt_state = WAIT_STOP;
        else if (startOfFrame && shootBtn)  nxt_state = CHARGE;
      end
      CHARGE: begin
        if (!ballStopped)                   nxt_state = WAIT_STOP;
        else if (startOfFrame && !shootBtn) nxt_state = (power == 8'd0) ? AIM : FIRE;
      end
      FIRE:   nxt_state = LAUNCH;
      LAUNCH: begin
        if (!ballStopped)                   nxt_state = WAIT_STOP;
        else if (startOfFrame && timer_q == TIMER_LAST) nxt_state = WAIT_STOP;
      end
      default: nxt_state = WAIT_STOP;
    endcase
  end

  // Launch vector: power x Q6 table, divided by 64 truncating toward zero
  always_comb begin
    power_s = $signed({1'b0, power});
    cos_v   = cos_q6(aimIndex);
    sin_v   = cos_q6(aimIndex + 4'd12);
    prod_x  = 17'(power_s) * 17'(cos_v);
    prod_y  = 17'(power_s) * 17'(sin_v);
    // bias negatives by 63 so the arithmetic shift rounds toward zero
    adj_x   = prod_x + (prod_x[16] ? 17'sd63 : 17'sd0);
    adj_y   = prod_y + (prod_y[16] ? 17'sd63 : 17'sd0);
    vx_d    = 11'(adj_x >>> 6);
    vy_d    = 11'(adj_y >>> 6);
  end

  // Output/datapath next values per state
  always_comb begin
    aim_d      = aimIndex;
    power_d    = power;
    count_d    = shotCount;
    timer_d    = timer_q;
    we_d       = 1'b0;
    charge_sum = {1'b0, power} + 9'(CHARGE_STEP);
    case (cur_state)
      AIM: begin
        if (!ballStopped) begin
          power_d = '0;
        end else if (startOfFrame) begin
          if (aimRight && !aimLeft)      aim_d = aimIndex + 4'd1;
          else if (aimLeft && !aimRight) aim_d = aimIndex - 4'd1;
          if (shootBtn) power_d = '0;
        end
      end
      CHARGE: begin
        if (!ballStopped) begin
          power_d = '0;
        end else if (startOfFrame && shootBtn) begin
          power_d = (charge_sum >= 9'(MAX_POWER)) ? 8'(MAX_POWER) : charge_sum[7:0];
        end
      end
      FIRE: begin
        we_d    = 1'b1;
        count_d = shotCount + 8'd1;
        power_d = '0;
        timer_d = '0;
      end
      LAUNCH: begin
        if (!ballStopped) begin
          timer_d = '0;
        end else if (startOfFrame) begin
          timer_d = (timer_q == TIMER_LAST) ? '0 : timer_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs; velocity only loads on the FIRE cycle and is held after
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      aimIndex            <= '0;
      power               <= '0;
      shotCount           <= '0;
      timer_q             <= '0;
      velocityWriteEnable <= 1'b0;
      outVelocityX        <= '0;
      outVelocityY        <= '0;
    end else begin
      aimIndex            <= aim_d;
      power               <= power_d;
      shotCount           <= count_d;
      timer_q             <= timer_d;
      velocityWriteEnable <= we_d;
      if (cur_state == FIRE) begin
        outVelocityX <= vx_d;
        outVelocityY <= vy_d;
      end
    end
  end

  assign state = cur_state;

endmodule

// File: doc/cue_shot_controller.md
# cue_shot_controller

Player-facing writer for a ball's velocity-write port. It aims and charges a cue shot while the cue ball is at rest, then issues a single-cycle velocity write carrying the launch vector. It sits between the player input debouncers and the cue ball's `velocityWriteEnable`/`inVelocityX`/`inVelocityY` inputs, and uses that ball's `ballStopped` output as its only feedback.

## Interface
- `MAX_POWER`, default 200: power saturation value; equals the ball velocity limit.
- `CHARGE_STEP`, default 4: power added per frame while charging.
- `LAUNCH_TIMEOUT`, default 8: number of frames to wait for the ball to start moving after a write.
- `clk` in 1: system clock.
- `resetN` in 1: asynchronous reset, active-high (asserted at 1).
- `startOfFrame` in 1: one-cycle frame strobe.
- `ballStopped` in 1: cue ball is at rest.
- `aimLeft`, `aimRight` in 1 each: debounced levels, sampled only at `startOfFrame`.
- `shootBtn` in 1: debounced level. Holding it charges; releasing it fires.
- `velocityWriteEnable` out 1: one-cycle write strobe to the ball.
- `outVelocityX`, `outVelocityY` out 11 signed: launch velocity, held after the write.
- `aimIndex` out 4: aim direction k. The angle is k·22.5°, with 0 pointing to +X and 4 pointing to +Y (screen down).
- `power` out 8: current charge, for the HUD.
- `shotCount` out 8: number of shots fired; wraps modulo 256.
- `state` out 3: FSM state code, for HUD and debug.

## Operation
- States and codes: WAIT_STOP=0, AIM=1, CHARGE=2, FIRE=3, LAUNCH=4.
- WAIT_STOP: on a `startOfFrame` cycle with `ballStopped`=1, go to AIM.
- AIM, evaluated per `startOfFrame` cycle:
  - `aimRight` only: `aimIndex`+1, mod 16.
  - `aimLeft` only: `aimIndex`−1, mod 16.
  - Both or neither: `aimIndex` holds.
  - `shootBtn`=1: clear `power` to 0 and go to CHARGE. Aim still updates that frame.
- CHARGE, evaluated per `startOfFrame` cycle:
  - `shootBtn`=1: `power` = min(`power`+`CHARGE_STEP`, `MAX_POWER`).
  - `shootBtn`=0 with `power`=0: return to AIM.
  - `shootBtn`=0 with `power`>0: go to FIRE.
  - Aim inputs are ignored.
- Abort: `ballStopped`=0 in AIM or CHARGE, on any cycle, sends the FSM to WAIT_STOP and clears `power`. No write is issued.
- FIRE lasts exactly one cycle:
  - Load `outVelocityX` = trunc0(`power`·COS[k]/64) and `outVelocityY` = trunc0(`power`·SIN[k]/64).
  - Pulse `velocityWriteEnable`.
  - Increment `shotCount`.
  - Go to LAUNCH.
- Q6 tables:
  - COS[0..15] = 64,59,45,24,0,−24,−45,−59,−64,−59,−45,−24,0,24,45,59.
  - SIN[k] = COS[(k+12) mod 16].
- Arithmetic:
  - Unsigned 8-bit `power` times signed 8-bit table entry gives a signed 17-bit product.
  - The product is divided by 64, truncating toward zero, so results are symmetric in sign.
  - The result is sign-fit to 11 bits. |v| ≤ 200, so it never overflows.
- LAUNCH:
  - `ballStopped`=0 on any cycle: go to WAIT_STOP.
  - Otherwise, count `startOfFrame` strobes. On the `LAUNCH_TIMEOUT`-th strobe, go to WAIT_STOP. This covers a write that produced a zero vector or was lost.
  - `power` clears on entry to LAUNCH.
- `aimIndex` persists across shots. Only reset clears it.

## Timing
- Reset values:
  - `state`=WAIT_STOP.
  - `aimIndex`=0, `power`=0, `shotCount`=0.
  - `outVelocityX`=`outVelocityY`=0.
  - `velocityWriteEnable`=0.
  - Timeout counter=0.
- Reset mid-CHARGE or mid-FIRE: outputs return to reset values asynchronously. No write pulse may escape.
- All outputs are registered. There are no combinational input-to-output paths.
- Fire latency:
  - Release is sampled on the `startOfFrame` cycle N; `state`=FIRE from cycle N+1.
  - `velocityWriteEnable`=1 during cycle N+2 only. `outVelocityX`/`outVelocityY` are valid in that same cycle and held afterwards.
  - `shotCount` increments at the same edge.
- `velocityWriteEnable` is high for exactly 1 clk per shot, never two in consecutive cycles, and never outside the FIRE→LAUNCH edge.
- `startOfFrame` coinciding with FIRE has no additional effect.
- `startOfFrame` coinciding with `ballStopped` falling in AIM or CHARGE: the abort wins.

## Test plan
- Reset, then `ballStopped`=1 and 3 frames idle → `state`=AIM, `aimIndex`=0, all velocities 0, no write.
- Hold `aimLeft` for 1 frame from index 0 → `aimIndex`=15. Then `aimLeft`+`aimRight` together for 2 frames → index stays 15.
- `aimIndex`=0, hold `shootBtn` for 60 frames, then release → `power` saturates at 200. A single write follows 2 cycles after the release frame with X=200, Y=0. `shotCount`=1.
- `aimIndex`=6, charge 10 frames (power 40), release → X=trunc0(40·−45/64)=−28, Y=trunc0(40·45/64)=28, with exactly one pulse.
- Drop `ballStopped` mid-CHARGE → `state`=WAIT_STOP, `power`=0, no pulse. Assert reset during FIRE → no pulse and all outputs at reset values.
- After a write, hold `ballStopped`=1 for 8 frames → LAUNCH times out to WAIT_STOP, then AIM. Then 256 shots → `shotCount` wraps to 0.
